// File: rtl/pipe_if_stage.sv
// Fetch stage plus IF/ID pipeline register: owns the PC, obeys the control unit's
// stall/redirect commands, squashes younger work on a MEM-resolved jump, and counts events.
module pipe_if_stage #(
  parameter int                PC_W     = 32,
  parameter int                INST_W   = 32,
  parameter logic [PC_W-1:0]   RESET_PC = '0,
  parameter logic [INST_W-1:0] NOP_INST = '0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              IFwip,
  input  logic              IDwir,
  input  logic              IFwillJump,
  input  logic [PC_W-1:0]   MEMtarget,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  output logic [INST_W-1:0] IDinst,
  output logic [PC_W-1:0]   IDpc4,
  output logic              IDvalid,
  output logic              flush_ex,
  output logic              misalign,
  output logic [15:0]       fetch_cnt,
  output logic [15:0]       squash_cnt,
  output logic [1:0]        dbg_state
);

  // Handshake: there is no valid/ready pair here. IFwip/IDwir are level enables
  // issued by the control unit each cycle; IDvalid qualifies IDinst/IDpc4 toward
  // decode, and flush_ex is a same-cycle kill toward ID/EX and EX/MEM.

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  state_t            state;
  logic [PC_W-1:0]   pc;
  logic [PC_W-1:0]   pc_plus4;
  logic [PC_W-1:0]   target;
  logic [INST_W-1:0] id_inst;
  logic [PC_W-1:0]   id_pc4;
  logic              id_valid;
  logic              mis;
  logic [15:0]       fcnt;
  logic [15:0]       scnt;

  assign pc_plus4 = pc + {{(PC_W-3){1'b0}}, 3'd4};
  // Word-aligned redirect; the dropped low bits are reported through misalign.
  assign target   = {MEMtarget[PC_W-1:2], 2'b00};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      id_inst  <= NOP_INST;
      id_pc4   <= '0;
      id_valid <= 1'b0;
      mis      <= 1'b0;
      fcnt     <= '0;
      scnt     <= '0;
    end else begin
      unique case (state)
        BOOT: begin
          state <= RUN;
        end
        RUN, REDIRECT: begin
          if (IFwillJump) begin
            // Redirect wins over any stall request arriving in the same cycle.
            state    <= REDIRECT;
            pc       <= target;
            id_inst  <= NOP_INST;
            id_valid <= 1'b0;
            scnt     <= scnt + 16'd1;
            if (|MEMtarget[1:0]) mis <= 1'b1;
          end else begin
            state <= RUN;
            if (IFwip) pc <= pc_plus4;
            if (IDwir) begin
              id_inst  <= imem_rdata;
              id_pc4   <= pc_plus4;
              id_valid <= 1'b1;
              fcnt     <= fcnt + 16'd1;
            end
          end
        end
        default: begin
          state <= BOOT;
        end
      endcase
    end
  end

  assign imem_addr  = pc;
  assign IDinst     = id_inst;
  assign IDpc4      = id_pc4;
  assign IDvalid    = id_valid;
  assign flush_ex   = IFwillJump & (state != BOOT);
  assign misalign   = mis;
  assign fetch_cnt  = fcnt;
  assign squash_cnt = scnt;
  assign dbg_state  = state;

endmodule

// File: tb/tb_pipe_if_stage.sv
// Bench for pipe_if_stage: directed scenarios then random control traffic, with a
// cycle-level reference model feeding an expected queue drained by a negedge monitor.
module tb_pipe_if_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  logic        clk;
  logic        resetn;
  logic        IFwip;
  logic        IDwir;
  logic        IFwillJump;
  logic [31:0] MEMtarget;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] IDinst;
  logic [31:0] IDpc4;
  logic        IDvalid;
  logic        flush_ex;
  logic        misalign;
  logic [15:0] fetch_cnt;
  logic [15:0] squash_cnt;
  logic [1:0]  dbg_state;

  pipe_if_stage #(
    .PC_W(32), .INST_W(32), .RESET_PC(RESET_PC), .NOP_INST(NOP_INST)
  ) dut (
    .clk(clk), .resetn(resetn), .IFwip(IFwip), .IDwir(IDwir),
    .IFwillJump(IFwillJump), .MEMtarget(MEMtarget), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .IDinst(IDinst), .IDpc4(IDpc4), .IDvalid(IDvalid),
    .flush_ex(flush_ex), .misalign(misalign), .fetch_cnt(fetch_cnt),
    .squash_cnt(squash_cnt), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: contents are a fixed function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction
  assign imem_rdata = mem_word(imem_addr);

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] inst;
    logic [31:0] pc4;
    logic        valid;
    logic        flush;
    logic        mis;
    logic        boot;
    logic [15:0] fc;
    logic [15:0] sc;
  } snap_t;

  snap_t exp_q[$];

  bit          m_known = 1'b0;
  bit          m_boot;
  logic [31:0] m_pc, m_inst, m_pc4;
  bit          m_valid, m_mis;
  int unsigned m_fc, m_sc;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Applies one cycle of inputs, records what the outputs must show this cycle,
  // then advances the model across the coming clock edge.
  task automatic step(input bit rn, input bit w, input bit r, input bit j,
                      input logic [31:0] t);
    snap_t s;
    logic [31:0] fetched;
    resetn = rn; IFwip = w; IDwir = r; IFwillJump = j; MEMtarget = t;
    if (m_known) begin
      s.addr  = m_pc;
      s.inst  = m_inst;
      s.pc4   = m_pc4;
      s.valid = m_valid;
      s.flush = j && !m_boot;
      s.mis   = m_mis;
      s.boot  = m_boot;
      s.fc    = 16'(m_fc);
      s.sc    = 16'(m_sc);
      exp_q.push_back(s);
    end
    if (!rn) begin
      m_known = 1'b1; m_boot = 1'b1;
      m_pc = RESET_PC; m_inst = NOP_INST; m_pc4 = 32'h0; m_valid = 1'b0;
      m_mis = 1'b0; m_fc = 0; m_sc = 0;
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (j) begin
      m_pc = t & 32'hFFFF_FFFC;
      m_inst = NOP_INST; m_valid = 1'b0;
      m_sc = (m_sc + 1) % 65536;
      if (t[1:0] != 2'b00) m_mis = 1'b1;
    end else begin
      fetched = mem_word(m_pc);
      if (r) begin
        m_inst = fetched; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
        m_fc = (m_fc + 1) % 65536;
      end
      if (w) m_pc = m_pc + 32'd4;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step(1, 1, 1, 0, 32'h0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  snap_t mon_e;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("imem_addr",  imem_addr,            mon_e.addr);
      chk("IDinst",     IDinst,               mon_e.inst);
      chk("IDpc4",      IDpc4,                mon_e.pc4);
      chk("IDvalid",    32'(IDvalid),         32'(mon_e.valid));
      chk("flush_ex",   32'(flush_ex),        32'(mon_e.flush));
      chk("misalign",   32'(misalign),        32'(mon_e.mis));
      chk("fetch_cnt",  32'(fetch_cnt),       32'(mon_e.fc));
      chk("squash_cnt", 32'(squash_cnt),      32'(mon_e.sc));
      chk("boot_state", 32'(dbg_state == 2'd0), 32'(mon_e.boot));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit rn, w, r, j;
    logic [31:0] t;

    // free run from reset: addr 0,0,4,8
    step(0, 0, 0, 0, 32'h0);
    run(3);
    // stall two cycles at PC=8
    step(1, 0, 0, 0, 32'h0);
    step(1, 0, 0, 0, 32'h0);
    run(2);
    // jump at PC=0x10 to 0x40
    step(1, 1, 1, 1, 32'h0000_0040);
    run(3);
    // jump with stall in the same cycle
    step(1, 0, 0, 1, 32'h0000_0080);
    run(2);
    // IFwip without IDwir drops the instruction
    step(1, 1, 0, 0, 32'h0);
    run(1);
    // misaligned target, misalign must stick
    step(1, 1, 1, 1, 32'h0000_0043);
    run(4);
    // back-to-back redirects
    step(1, 1, 1, 1, 32'h0000_0100);
    step(1, 1, 1, 1, 32'h0000_0200);
    run(2);
    // reset while in REDIRECT with a jump pending; inputs ignored in BOOT
    step(1, 1, 1, 1, 32'h0000_0300);
    step(0, 1, 1, 1, 32'h0000_0400);
    step(1, 1, 1, 1, 32'h0000_0500);
    run(3);
    // PC wrap at the top of the address space
    step(1, 1, 1, 1, 32'hFFFF_FFF8);
    run(4);

    for (int i = 0; i < 3000; i++) begin
      rn = ($urandom_range(0, 199) != 0);
      j  = ($urandom_range(0, 5) == 0);
      w  = ($urandom_range(0, 3) != 0);
      r  = ($urandom_range(0, 9) == 0) ? 1'($urandom_range(0, 1)) : w;
      t  = $urandom;
      if ($urandom_range(0, 1) == 1) t[1:0] = 2'b00;
      step(rn, w, r, j, t);
    end
    step(1, 0, 0, 0, 32'h0);

    for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: actual=%0d pending expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
